// File: rtl/or1200_enc_sched.sv
// Round-robin scheduler sharing one cache-line crypto engine between the IC and DC requesters.
// Optional watchdog on the engine wait: define OR1200_ENC_SCHED_TIMEOUT_EN.
module or1200_enc_sched #(
  parameter int AW             = 32,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req_i,
  input  logic [AW-1:0] ic_addr_i,
  input  logic          dc_req_i,
  input  logic [AW-1:0] dc_addr_i,
  input  logic          eng_done_i,
  output logic          eng_start_o,
  output logic [AW-1:0] eng_addr_o,
  output logic          eng_sel_o,
  output logic          ic_unstall_o,
  output logic          dc_unstall_o,
  output logic          busy_o,
  output logic          timeout_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..2**CNT_W-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;        // 0=IC, 1=DC
  logic          ic_mask_q, ic_mask_d;
  logic          dc_mask_q, dc_mask_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          sel_q, sel_d;
  logic          start_q, start_d;
  logic          ic_un_q, ic_un_d;
  logic          dc_un_q, dc_un_d;
  logic          busy_q, busy_d;
  logic          ic_eff, dc_eff, grant_dc;

`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  assign ic_eff = ic_req_i & ~ic_mask_q;
  assign dc_eff = dc_req_i & ~dc_mask_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ic_mask_d = ic_mask_q;
    dc_mask_d = dc_mask_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    start_d   = 1'b0;
    ic_un_d   = 1'b0;
    dc_un_d   = 1'b0;
    grant_dc  = 1'b0;
`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // On a tie the requester not served last wins.
        grant_dc  = dc_eff & (~ic_eff | ~last_q);
        ic_mask_d = 1'b0;
        dc_mask_d = 1'b0;
        if (ic_eff | dc_eff) begin
          addr_d  = grant_dc ? dc_addr_i : ic_addr_i;
          sel_d   = grant_dc;
          last_d  = grant_dc;
          start_d = 1'b1;
          state_d = S_ISSUE;
`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (eng_done_i) begin
          state_d = S_DONE;
          ic_un_d = ~sel_q;
          dc_un_d = sel_q;
        end
`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          ic_un_d = ~sel_q;
          dc_un_d = sel_q;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        // Masks hide a request still held for the cycle after its unstall.
        ic_mask_d = ~sel_q;
        dc_mask_d = sel_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      ic_mask_q <= 1'b0;
      dc_mask_q <= 1'b0;
      addr_q    <= '0;
      sel_q     <= 1'b0;
      start_q   <= 1'b0;
      ic_un_q   <= 1'b0;
      dc_un_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ic_mask_q <= ic_mask_d;
      dc_mask_q <= dc_mask_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      ic_un_q   <= ic_un_d;
      dc_un_q   <= dc_un_d;
      busy_q    <= busy_d;
    end
  end

`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign eng_start_o  = start_q;
  assign eng_addr_o   = addr_q;
  assign eng_sel_o    = sel_q;
  assign ic_unstall_o = ic_un_q;
  assign dc_unstall_o = dc_un_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_or1200_enc_sched.sv
// Scoreboard bench for or1200_enc_sched: expected grants are queued when requests are driven
// and checked when the engine start appears; unstalls are checked against the open grant.
module tb_or1200_enc_sched;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_req_i = 1'b0, dc_req_i = 1'b0, eng_done_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0, dc_addr_i = '0;
  logic          eng_start_o, eng_sel_o, ic_unstall_o, dc_unstall_o, busy_o, timeout_o;
  logic [AW-1:0] eng_addr_o;

  always #5 clk = ~clk;

  or1200_enc_sched #(.AW(AW), .CNT_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i),
    .eng_done_i(eng_done_i),
    .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o), .eng_sel_o(eng_sel_o),
    .ic_unstall_o(ic_unstall_o), .dc_unstall_o(dc_unstall_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t exp_q[$];
  logic pend = 1'b0, pend_sel = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic sel, input logic [AW-1:0] addr);
    exp_t e;
    e.sel  = sel;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (eng_start_o) found = 1'b1;
      else step();
    end
    if (!found) chk(tag, 0, 1);
  endtask

  task automatic wait_unstall(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ic_unstall_o | dc_unstall_o) found = 1'b1;
      else step();
    end
    if (!found) chk(tag, 0, 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (eng_start_o) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant_sel", eng_sel_o, e.sel);
          chk("grant_addr", eng_addr_o, e.addr);
          pend     = 1'b1;
          pend_sel = e.sel;
        end
      end
      if (ic_unstall_o | dc_unstall_o) begin
        chk("unstall_pending", pend, 1);
        chk("unstall_side", {ic_unstall_o, dc_unstall_o}, pend_sel ? 2'b01 : 2'b10);
        pend = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_start", eng_start_o, 0);
    chk("rst_addr", eng_addr_o, 0);
    chk("rst_sel", eng_sel_o, 0);
    chk("rst_ic_un", ic_unstall_o, 0);
    chk("rst_dc_un", dc_unstall_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst = 1'b1;

    // Single IC request, done at cycle 5.
    ic_addr_i = 32'h0000_1000; ic_req_i = 1'b1; push(1'b0, 32'h0000_1000);
    step();
    chk("t1_start", eng_start_o, 1);
    chk("t1_sel", eng_sel_o, 0);
    chk("t1_addr", eng_addr_o, 32'h0000_1000);
    chk("t1_busy", busy_o, 1);
    step();
    chk("t1_start_once", eng_start_o, 0);
    step(); step(); step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    chk("t1_ic_unstall", ic_unstall_o, 1);
    chk("t1_dc_quiet", dc_unstall_o, 0);
    chk("t1_busy_done", busy_o, 1);
    ic_req_i = 1'b0;
    step();
    chk("t1_unstall_pulse", ic_unstall_o, 0);
    chk("t1_idle", busy_o, 0);
    chk("t1_addr_hold", eng_addr_o, 32'h0000_1000);

    // Both requests held from reset: IC, DC, IC.
    rst = 1'b0;
    ic_req_i = 1'b1; dc_req_i = 1'b1;
    ic_addr_i = 32'h0000_00A0; dc_addr_i = 32'h0000_00B0;
    push(1'b0, 32'h0000_00A0); push(1'b1, 32'h0000_00B0); push(1'b0, 32'h0000_00A0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_start("t2_start");
      step(); step();
      eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
      wait_unstall("t2_unstall");
      if (k == 2) begin
        ic_req_i = 1'b0; dc_req_i = 1'b0;
      end
      step();
    end
    step();
    chk("t2_sb_drained", exp_q.size(), 0);

    // IC request held one cycle past its unstall must not be re-granted.
    ic_addr_i = 32'h0000_3000; ic_req_i = 1'b1; push(1'b0, 32'h0000_3000);
    wait_start("t3_start");
    step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    wait_unstall("t3_unstall");
    step();
    chk("t3_masked_idle", busy_o, 0);
    step();
    chk("t3_no_regrant", eng_start_o, 0);
    ic_req_i = 1'b0;
    step();
    chk("t3_no_regrant2", eng_start_o, 0);
    chk("t3_still_idle", busy_o, 0);

    // Async reset during WAIT abandons the transaction.
    ic_addr_i = 32'h0000_2000; ic_req_i = 1'b1; push(1'b0, 32'h0000_2000);
    wait_start("t4_start");
    step();
    #2 rst = 1'b0;
    #1;
    chk("t4_rst_busy", busy_o, 0);
    chk("t4_rst_start", eng_start_o, 0);
    chk("t4_rst_addr", eng_addr_o, 0);
    chk("t4_rst_sel", eng_sel_o, 0);
    chk("t4_rst_unstall", {ic_unstall_o, dc_unstall_o}, 0);
    ic_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    chk("t4_no_unstall", {ic_unstall_o, dc_unstall_o}, 0);
    chk("t4_idle", busy_o, 0);
    step();
    chk("t4_no_unstall2", {ic_unstall_o, dc_unstall_o}, 0);
    dc_addr_i = 32'h0000_6000; dc_req_i = 1'b1; push(1'b1, 32'h0000_6000);
    wait_start("t4_regrant");
    step(); step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    wait_unstall("t4_unstall");
    chk("t4_dc_unstall", dc_unstall_o, 1);
    dc_req_i = 1'b0;
    step();

    // eng_done_i in IDLE and in ISSUE is ignored.
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    chk("t5_idle_busy", busy_o, 0);
    chk("t5_idle_unstall", {ic_unstall_o, dc_unstall_o}, 0);
    ic_addr_i = 32'h0000_7000; ic_req_i = 1'b1; push(1'b0, 32'h0000_7000);
    wait_start("t5_start");
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    chk("t5_issue_unstall", {ic_unstall_o, dc_unstall_o}, 0);
    chk("t5_issue_busy", busy_o, 1);
    step();
    chk("t5_issue_unstall2", {ic_unstall_o, dc_unstall_o}, 0);
`ifndef OR1200_ENC_SCHED_TIMEOUT_EN
    repeat (10) step();
    chk("t5_wait_forever", busy_o, 1);
    chk("t5_no_timeout", timeout_o, 0);
`endif
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    wait_unstall("t5_unstall");
    ic_req_i = 1'b0;
    step();

`ifdef OR1200_ENC_SCHED_TIMEOUT_EN
    // Watchdog expiry with no done.
    ic_addr_i = 32'h0000_4000; ic_req_i = 1'b1; push(1'b0, 32'h0000_4000);
    wait_start("t6_start");
    chk("t6_to_clear", timeout_o, 0);
    repeat (4) step();
    chk("t6_not_yet", ic_unstall_o, 0);
    step();
    chk("t6_unstall", ic_unstall_o, 1);
    chk("t6_timeout", timeout_o, 1);
    ic_req_i = 1'b0;
    step();
    chk("t6_timeout_held", timeout_o, 1);
    chk("t6_idle", busy_o, 0);
    dc_addr_i = 32'h0000_5000; dc_req_i = 1'b1; push(1'b1, 32'h0000_5000);
    wait_start("t6_start2");
    chk("t6_cleared_on_grant", timeout_o, 0);
    step(); step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    wait_unstall("t6_unstall2");
    chk("t6_normal_no_to", timeout_o, 0);
    dc_req_i = 1'b0;
    step();
    // Done coinciding with expiry is a normal completion.
    ic_addr_i = 32'h0000_4100; ic_req_i = 1'b1; push(1'b0, 32'h0000_4100);
    wait_start("t6_start3");
    repeat (4) step();
    eng_done_i = 1'b1; step(); eng_done_i = 1'b0;
    chk("t6_tie_unstall", ic_unstall_o, 1);
    chk("t6_tie_no_to", timeout_o, 0);
    ic_req_i = 1'b0;
    step();
`endif

    repeat (3) step();
    chk("sb_empty", exp_q.size(), 0);
    chk("no_open_grant", pend, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
